data_mem_bridge: RTL and testbench

Sits between the single-cycle MIPS core's data-memory port and a valid/ready memory bus; converts the core's one-cycle load/store request into a bus transaction and stalls the core until it completes. One outstanding transaction; stores are posted (complete on request handshake), loads complete on response handshake. Also keeps request and stall-cycle counters for performance measurement.

---
 rtl/data_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_data_mem_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: converts the single-cycle MIPS core's data-memory access into a valid/ready bus transaction.
// Latency: store stalls >= 2 cycles (IDLE, REQ), load >= 3 (IDLE, REQ, WAIT_RSP); each bus wait cycle adds one.
// Backpressure: request held stable while mem_req_ready is low; core stalled combinationally until DONE.
module data_mem_bridge #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // core data-memory port
  input  logic [31:0]          cpu_Address,
  input  logic                 cpu_MemRead,
  input  logic                 cpu_MemWrite,
  input  logic [31:0]          cpu_Write_data,
  input  logic [3:0]           cpu_Write_strb,
  output logic [31:0]          cpu_Read_data,
  output logic                 cpu_stall,
  // bus request channel
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_wen,
  output logic [31:0]          mem_req_addr,
  output logic [31:0]          mem_req_wdata,
  output logic [3:0]           mem_req_strb,
  // bus response channel
  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic [31:0]          mem_rsp_rdata,
  // performance counters
  output logic [CNT_WIDTH-1:0] req_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_wen;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_strb;
  logic [31:0]          r_rdata;
  logic [CNT_WIDTH-1:0] r_req_count;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic                 w_cpu_req;
  logic                 w_capture;
  logic                 w_rsp_take;
  logic                 w_enter_done;
  logic                 w_stall;
  logic                 w_req_valid;
  logic                 w_rsp_ready;

  // A store wins when both read and write are asserted.
  assign w_cpu_req = cpu_MemRead | cpu_MemWrite;

  // Next-state decode plus the per-state bus/core strobes.
  always_comb begin
    w_next_state = r_state;
    w_enter_done = 1'b0;
    w_capture    = 1'b0;
    w_rsp_take   = 1'b0;
    w_stall      = 1'b0;
    w_req_valid  = 1'b0;
    w_rsp_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_cpu_req;
        if (w_cpu_req) begin
          w_capture    = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (mem_req_ready) begin
          // stores are posted: the request handshake completes them
          if (r_wen) begin
            w_next_state = S_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_next_state = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        w_stall     = 1'b1;
        w_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          w_rsp_take   = 1'b1;
          w_next_state = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE: begin
        // core advances on this edge; a held request is seen in the next IDLE
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request registers: captured only when leaving IDLE, so core changes later are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_strb  <= 4'd0;
    end else if (w_capture) begin
      r_wen   <= cpu_MemWrite;
      r_addr  <= cpu_Address;
      r_wdata <= cpu_Write_data;
      r_strb  <= cpu_MemWrite ? cpu_Write_strb : 4'b1111;
    end
  end

  // Load result register; holds the last load value across stores and idle time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (w_rsp_take) begin
      r_rdata <= mem_rsp_rdata;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_enter_done && (r_req_count != CNT_MAX)) begin
        r_req_count <= r_req_count + CNT_ONE;
      end
      if (w_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end
  end

  assign cpu_stall     = w_stall;
  assign cpu_Read_data = r_rdata;
  assign mem_req_valid = w_req_valid;
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_strb  = r_strb;
  assign mem_rsp_ready = w_rsp_ready;
  assign req_count     = r_req_count;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: a 32-bit-counter instance and a 4-bit-counter instance share stimulus.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Bus ready/response behaviour is scripted per scenario.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_Address;
  logic        cpu_MemRead;
  logic        cpu_MemWrite;
  logic [31:0] cpu_Write_data;
  logic [3:0]  cpu_Write_strb;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  logic [31:0] cpu_Read_data;
  logic        cpu_stall;
  logic        mem_req_valid;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_strb;
  logic        mem_rsp_ready;
  logic [31:0] req_count;
  logic [31:0] stall_count;

  logic [31:0] s_Read_data;
  logic        s_stall;
  logic        s_req_valid;
  logic        s_req_wen;
  logic [31:0] s_req_addr;
  logic [31:0] s_req_wdata;
  logic [3:0]  s_req_strb;
  logic        s_rsp_ready;
  logic [3:0]  s_req_count;
  logic [3:0]  s_stall_count;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  data_mem_bridge #(.CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_Address(cpu_Address), .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
    .cpu_Write_data(cpu_Write_data), .cpu_Write_strb(cpu_Write_strb),
    .cpu_Read_data(cpu_Read_data), .cpu_stall(cpu_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .req_count(req_count), .stall_count(stall_count)
  );

  data_mem_bridge #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst),
    .cpu_Address(cpu_Address), .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
    .cpu_Write_data(cpu_Write_data), .cpu_Write_strb(cpu_Write_strb),
    .cpu_Read_data(s_Read_data), .cpu_stall(s_stall),
    .mem_req_valid(s_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(s_req_wen),
    .mem_req_addr(s_req_addr), .mem_req_wdata(s_req_wdata), .mem_req_strb(s_req_strb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(s_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .req_count(s_req_count), .stall_count(s_stall_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_Address = 32'd0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
    cpu_Write_data = 32'd0; cpu_Write_strb = 4'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    #1 rst = 1'b0;
    #2;
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_req_wen, mem_rsp_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {cpu_stall, mem_req_valid, mem_req_wen, mem_rsp_ready});
    end
    n_asserts++;
    if ({mem_req_addr, mem_req_wdata, cpu_Read_data, mem_req_strb} !== 100'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h strb %h required all zero", mem_req_addr, mem_req_wdata, cpu_Read_data, mem_req_strb);
    end
    n_asserts++;
    if ({req_count, stall_count, s_req_count, s_stall_count} !== 72'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d %0d %0d %0d required 0", req_count, stall_count, s_req_count, s_stall_count);
    end
    cpu_MemRead = 1'b1;
    #1;
    n_asserts++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall_follows_req: got %b required 1", cpu_stall);
    end
    cpu_MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Load 0x10, ready=1, response the cycle after accept.
  task automatic test_load();
    step();
    cpu_MemRead = 1'b1; cpu_Address = 32'h0000_0010; mem_req_ready = 1'b1;
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b100) begin
      n_fail++; $display("FAIL load_idle: stall/valid/rsp_rdy %b required 100", {cpu_stall, mem_req_valid, mem_rsp_ready});
    end
    step();
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_rsp_ready, mem_req_wen} !== 4'b1100 ||
        mem_req_addr !== 32'h10 || mem_req_strb !== 4'hF) begin
      n_fail++; $display("FAIL load_req: ctl %b addr %h strb %h required 1100 00000010 f", {cpu_stall, mem_req_valid, mem_rsp_ready, mem_req_wen}, mem_req_addr, mem_req_strb);
    end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b101) begin
      n_fail++; $display("FAIL load_wait: ctl %b required 101", {cpu_stall, mem_req_valid, mem_rsp_ready});
    end
    step();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    @(negedge clk);
    n_asserts++;
    if (cpu_stall !== 1'b0 || cpu_Read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_done: stall %b rdata %h required 0 deadbeef", cpu_stall, cpu_Read_data);
    end
    n_asserts++;
    if (req_count !== 32'd1 || stall_count !== 32'd3) begin
      n_fail++; $display("FAIL load_counts: req %0d stall %0d required 1 3", req_count, stall_count);
    end
    step();
    cpu_MemRead = 1'b0;
  endtask

  // Store with ready held low two cycles; core inputs scrambled while the request is pending.
  task automatic test_store();
    cpu_MemWrite = 1'b1; cpu_Address = 32'h0000_0020;
    cpu_Write_data = 32'h1234_5678; cpu_Write_strb = 4'b0011; mem_req_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid} !== 2'b10) begin
      n_fail++; $display("FAIL store_idle: stall/valid %b required 10", {cpu_stall, mem_req_valid});
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 1) begin
        cpu_Address = 32'hFFFF_FFFC; cpu_Write_data = 32'h0; cpu_Write_strb = 4'hF;
      end
      if (c == 2) mem_req_ready = 1'b1;
      @(negedge clk);
      n_asserts++;
      if ({cpu_stall, mem_req_valid, mem_rsp_ready, mem_req_wen} !== 4'b1101 || mem_req_addr !== 32'h20 ||
          mem_req_wdata !== 32'h1234_5678 || mem_req_strb !== 4'b0011) begin
        n_fail++; $display("FAIL store_req_c%0d: ctl %b addr %h data %h strb %b required 1101 00000020 12345678 0011", c, {cpu_stall, mem_req_valid, mem_rsp_ready, mem_req_wen}, mem_req_addr, mem_req_wdata, mem_req_strb);
      end
    end
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b000 || cpu_Read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_done: ctl %b rdata %h required 000 deadbeef", {cpu_stall, mem_req_valid, mem_rsp_ready}, cpu_Read_data);
    end
    n_asserts++;
    if (req_count !== 32'd2 || stall_count !== 32'd7) begin
      n_fail++; $display("FAIL store_counts: req %0d stall %0d required 2 7", req_count, stall_count);
    end
    step();
    cpu_MemWrite = 1'b0;
  endtask

  // Read and write both asserted: a single store goes out.
  task automatic test_read_write_both();
    cpu_MemRead = 1'b1; cpu_MemWrite = 1'b1; cpu_Address = 32'h0000_0040;
    cpu_Write_data = 32'hA5A5_A5A5; cpu_Write_strb = 4'hF; mem_req_ready = 1'b1;
    step();
    @(negedge clk);
    n_asserts++;
    if ({mem_req_valid, mem_req_wen} !== 2'b11 || mem_req_addr !== 32'h40 || mem_req_wdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL both_req: valid/wen %b addr %h data %h required 11 00000040 a5a5a5a5", {mem_req_valid, mem_req_wen}, mem_req_addr, mem_req_wdata);
    end
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_rsp_ready} !== 2'b00 || cpu_Read_data !== 32'hDEAD_BEEF || req_count !== 32'd3 || stall_count !== 32'd9) begin
      n_fail++; $display("FAIL both_done: stall/rsp_rdy %b rdata %h req %0d stall %0d required 00 deadbeef 3 9", {cpu_stall, mem_rsp_ready}, cpu_Read_data, req_count, stall_count);
    end
    step();
    cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
  endtask

  // Spurious response while idle, then a load whose response arrives in the fifth wait cycle.
  task automatic test_delayed_load();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_asserts++;
      if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b000 || cpu_Read_data !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL spurious_idle_c%0d: ctl %b rdata %h required 000 deadbeef", c, {cpu_stall, mem_req_valid, mem_rsp_ready}, cpu_Read_data);
      end
      step();
    end
    mem_rsp_valid = 1'b0;
    cpu_MemRead = 1'b1; cpu_Address = 32'h0000_0080; mem_req_ready = 1'b1;
    step();
    @(negedge clk);
    n_asserts++;
    if ({mem_req_valid, mem_req_wen} !== 2'b10 || mem_req_addr !== 32'h80 || mem_req_strb !== 4'hF) begin
      n_fail++; $display("FAIL dload_req: valid/wen %b addr %h strb %h required 10 00000080 f", {mem_req_valid, mem_req_wen}, mem_req_addr, mem_req_strb);
    end
    step();
    mem_req_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
      end
      @(negedge clk);
      n_asserts++;
      if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b101 || cpu_Read_data !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL dload_wait_%0d: ctl %b rdata %h required 101 deadbeef", k, {cpu_stall, mem_req_valid, mem_rsp_ready}, cpu_Read_data);
      end
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    @(negedge clk);
    n_asserts++;
    if (cpu_stall !== 1'b0 || cpu_Read_data !== 32'hCAFE_F00D || req_count !== 32'd4 || stall_count !== 32'd16) begin
      n_fail++; $display("FAIL dload_done: stall %b rdata %h req %0d stall %0d required 0 cafef00d 4 16", cpu_stall, cpu_Read_data, req_count, stall_count);
    end
    step();
    cpu_MemRead = 1'b0;
  endtask

  // Store request held through DONE: one IDLE cycle separates consecutive transactions.
  task automatic test_back_to_back();
    bit exp_st[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit exp_v[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_addr;
    cpu_MemWrite = 1'b1; cpu_Address = 32'h0000_0200;
    cpu_Write_data = 32'h0BAD_F00D; cpu_Write_strb = 4'hF; mem_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_addr = (c < 3) ? 32'h200 : 32'h204;
      @(negedge clk);
      n_asserts++;
      if ({cpu_stall, mem_req_valid} !== {exp_st[c], exp_v[c]} || (mem_req_valid === 1'b1 && mem_req_addr !== exp_addr)) begin
        n_fail++; $display("FAIL b2b_c%0d: stall/valid %b addr %h required %b%b %h", c, {cpu_stall, mem_req_valid}, mem_req_addr, exp_st[c], exp_v[c], exp_addr);
      end
      step();
      if (c == 2) cpu_Address = 32'h0000_0204;
    end
    cpu_MemWrite = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (cpu_stall !== 1'b0 || req_count !== 32'd6 || stall_count !== 32'd20) begin
      n_fail++; $display("FAIL b2b_counts: stall %b req %0d stall %0d required 0 6 20", cpu_stall, req_count, stall_count);
    end
  endtask

  // Reset asserted while waiting for a load response.
  task automatic test_reset_mid();
    step();
    cpu_MemRead = 1'b1; cpu_Address = 32'h0000_0300; mem_req_ready = 1'b1;
    step();
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mem_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: rsp_ready %b required 1", mem_rsp_ready);
    end
    #2 rst = 1'b0;
    #1;
    n_asserts++;
    if ({mem_req_valid, mem_req_wen, mem_rsp_ready, mem_req_strb} !== 7'd0 ||
        {mem_req_addr, mem_req_wdata, cpu_Read_data} !== 96'd0 || {req_count, stall_count} !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: ctl %b addr %h rdata %h req %0d stall %0d required all zero", {mem_req_valid, mem_req_wen, mem_rsp_ready, mem_req_strb}, mem_req_addr, cpu_Read_data, req_count, stall_count);
    end
    n_asserts++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_stall_eq: got %b required 1", cpu_stall);
    end
    cpu_MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    n_asserts++;
    if ({cpu_stall, mem_req_valid, mem_rsp_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_no_retry: ctl %b required 000", {cpu_stall, mem_req_valid, mem_rsp_ready});
    end
  endtask

  // Twenty back-to-back stores: 4-bit counters clamp at 15, 32-bit ones keep counting.
  task automatic test_saturation();
    int dones = 0;
    step();
    cpu_MemWrite = 1'b1; cpu_Address = 32'h0000_0400;
    cpu_Write_data = 32'h5555_AAAA; cpu_Write_strb = 4'hF; mem_req_ready = 1'b1;
    for (int c = 0; c < 100 && dones < 20; c++) begin
      @(negedge clk);
      if (cpu_stall === 1'b0) begin
        dones++;
        if (dones == 14) begin
          n_asserts++;
          if (s_req_count !== 4'd14 || s_stall_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_14: req %0d stall %0d required 14 15", s_req_count, s_stall_count);
          end
        end
        if (dones == 20) begin
          n_asserts++;
          if (s_req_count !== 4'd15 || s_stall_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_20: req %0d stall %0d required 15 15", s_req_count, s_stall_count);
          end
          n_asserts++;
          if (req_count !== 32'd20 || stall_count !== 32'd40) begin
            n_fail++; $display("FAIL sat_wide: req %0d stall %0d required 20 40", req_count, stall_count);
          end
        end
      end
      step();
    end
    cpu_MemWrite = 1'b0; mem_req_ready = 1'b0;
    n_asserts++;
    if (dones != 20) begin
      n_fail++; $display("FAIL sat_timeout: completed %0d required 20", dones);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_read_write_both();
    test_delayed_load();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
